// File: rtl/transmitter_burst_ctrl.sv
// Burst sequencer for an I2C byte transmitter.
// A host loads a size, a burst count and up to eight bytes through a small
// register port. A start then replays buf[0..size-1] Tburst times. A one-cycle
// gap separates bursts, and a one-cycle done pulse closes the sequence.
// All state changes on the falling edge of clk.
module transmitter_burst_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Twrite,
    input  logic [3:0] Taddr,
    input  logic [7:0] Tdata,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] dataout1,
    output logic [7:0] dataout2
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_SIZE  = 4'd1;
    localparam logic [3:0] ADDR_BURST = 4'd2;
    localparam logic [3:0] ADDR_CTRL  = 4'd3;
    localparam logic [3:0] ADDR_PUSH  = 4'd4;

    state_t      state;
    logic [7:0]  tsize;
    logic [7:0]  tburst;
    logic [2:0]  wptr;
    logic [2:0]  index;
    logic [7:0]  burst_cnt;
    logic [7:0]  mem [0:7];

    logic        idle;
    logic        wr_size;
    logic        wr_burst;
    logic        wr_push;
    logic        wr_clear;
    logic        start;
    logic [3:0]  eff_size;
    logic        index_last;

    // Register writes are only honoured while the sequencer is idle, except
    // the start bit, which the FSM itself qualifies with IDLE.
    assign idle     = (state == IDLE);
    assign wr_size  = Twrite && (Taddr == ADDR_SIZE)  && idle;
    assign wr_burst = Twrite && (Taddr == ADDR_BURST) && idle;
    assign wr_push  = Twrite && (Taddr == ADDR_PUSH)  && idle;
    assign wr_clear = Twrite && (Taddr == ADDR_CTRL)  && Tdata[1] && idle;
    assign start    = Twrite && (Taddr == ADDR_CTRL)  && Tdata[0];

    // Clamp the programmed size into the 1..8 range the buffer supports.
    // NOTE: every branch assigns eff_size, so this block stays combinational and infers no latch.
    always_comb begin
        if (tsize == 8'd0) begin
            eff_size = 4'd1;
        end else if (tsize > 8'd8) begin
            eff_size = 4'd8;
        end else begin
            eff_size = tsize[3:0];
        end
    end

    assign index_last = ({1'b0, index} == (eff_size - 4'd1));

    // Byte buffer: written only by pushes, read by the sequencer.
    // NOTE: the buffer has no reset; its contents are don't-care until pushed, and leaving it unreset lets it map to plain storage.
    always_ff @(negedge clk) begin
        if (wr_push) begin
            mem[wptr] <= Tdata;
        end
    end

    // Configuration registers, write pointer, readback and sequencer FSM with registered outputs.
    // NOTE: non-blocking assignments throughout, so every register samples the values from before this edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tsize     <= 8'd0;
            tburst    <= 8'd0;
            wptr      <= 3'd0;
            index     <= 3'd0;
            burst_cnt <= 8'd0;
            dataout1  <= 8'd0;
            dataout2  <= 8'd0;
            tx_data   <= 8'd0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            dataout1 <= tsize;
            dataout2 <= tburst;

            if (wr_size) begin
                tsize <= Tdata;
            end
            if (wr_burst) begin
                tburst <= Tdata;
            end
            if (wr_clear) begin
                wptr <= 3'd0;
            end else if (wr_push) begin
                wptr <= wptr + 3'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (tburst != 8'd0) begin
                            state     <= SEND;
                            index     <= 3'd0;
                            burst_cnt <= 8'd0;
                            tx_valid  <= 1'b1;
                            tx_data   <= mem[0];
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (tx_ready) begin
                        if (!index_last) begin
                            index   <= index + 3'd1;
                            tx_data <= mem[index + 3'd1];
                        end else begin
                            index     <= 3'd0;
                            burst_cnt <= burst_cnt + 8'd1;
                            tx_valid  <= 1'b0;
                            if (burst_cnt + 8'd1 == tburst) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                end

                GAP: begin
                    state    <= SEND;
                    tx_valid <= 1'b1;
                    tx_data  <= mem[index];
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter_burst_ctrl.sv
// Self-checking bench for transmitter_burst_ctrl.
// Expected bytes and done pulses go into a scoreboard queue when a sequence
// is started. A monitor pops the queue on each accepted byte or done pulse.
// Inputs change just after the falling (active) edge.
// Outputs are sampled on the rising edge.
module tb_transmitter_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Twrite = 1'b0;
    logic [3:0] Taddr = 4'd0;
    logic [7:0] Tdata = 8'd0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       done;
    logic [7:0] dataout1;
    logic [7:0] dataout2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_done;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];

    transmitter_burst_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Twrite   (Twrite),
        .Taddr    (Taddr),
        .Tdata    (Tdata),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .done     (done),
        .dataout1 (dataout1),
        .dataout2 (dataout2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_event(input bit is_done, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %s 0x%0h, expected nothing", is_done ? "done" : "byte", data);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", {31'd0, is_done}, {31'd0, e.is_done});
            if (!e.is_done) begin
                check("sb_data", {24'd0, data}, {24'd0, e.data});
            end
        end
    endtask

    // Monitor: a byte counts as transferred when valid and ready are both high ahead of the active edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                sb_event(1'b0, tx_data);
            end
            if (done) begin
                sb_event(1'b1, 8'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        Twrite = 1'b1;
        Taddr  = a;
        Tdata  = d;
        tick();
        Twrite = 1'b0;
        Taddr  = 4'd0;
        Tdata  = 8'd0;
    endtask

    task automatic exp_byte(input logic [7:0] d);
        ev_t e;
        e.is_done = 1'b0;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_done();
        ev_t e;
        e.is_done = 1'b1;
        e.data    = 8'd0;
        exp_q.push_back(e);
    endtask

    // Wait until every expected event has been seen and the sequencer is idle again.
    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            tick();
            n++;
        end
        check(name, {31'd0, n < 500}, 32'd1);
        exp_q.delete();
    endtask

    // Count cycles from the start write until done, and how many of them had tx_valid high.
    task automatic run_obs(output int cyc, output int nvalid);
        cyc    = 0;
        nvalid = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            if (tx_valid) nvalid++;
            if (done) break;
        end
        tick();
    endtask

    initial begin
        int cyc;
        int nvalid;
        int n;

        // Reset state.
        #2;
        check("rst_tx_data", {24'd0, tx_data}, 32'h0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
        check("rst_dataout1", {24'd0, dataout1}, 32'h0);
        check("rst_dataout2", {24'd0, dataout2}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Two bursts of three bytes with the transmitter always ready.
        tx_ready = 1'b1;
        wr(4'd4, 8'hA1);
        wr(4'd4, 8'hB2);
        wr(4'd4, 8'hC3);
        wr(4'd1, 8'd3);
        wr(4'd2, 8'd2);
        tick();
        check("rb_tsize", {24'd0, dataout1}, 32'd3);
        check("rb_tburst", {24'd0, dataout2}, 32'd2);
        exp_byte(8'hA1); exp_byte(8'hB2); exp_byte(8'hC3);
        exp_byte(8'hA1); exp_byte(8'hB2); exp_byte(8'hC3);
        exp_done();
        wr(4'd3, 8'h01);
        run_obs(cyc, nvalid);
        check("burst2_cycles", cyc, 32'd8);
        check("burst2_valid_cycles", nvalid, 32'd6);
        wait_drain("burst2_drain");

        // Back-pressure: tx_data must hold buf[0] while tx_ready stays low.
        wr(4'd3, 8'h02);
        wr(4'd4, 8'h11);
        wr(4'd4, 8'h22);
        wr(4'd1, 8'd2);
        wr(4'd2, 8'd1);
        tx_ready = 1'b0;
        exp_byte(8'h11); exp_byte(8'h22); exp_done();
        wr(4'd3, 8'h01);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_data", {24'd0, tx_data}, 32'h11);
        end
        tick();
        tx_ready = 1'b1;
        @(posedge clk);
        check("hold_release_data", {24'd0, tx_data}, 32'h11);
        tick();
        wait_drain("hold_drain");

        // Tburst = 0: done on the next cycle, no bytes.
        wr(4'd2, 8'd0);
        exp_done();
        wr(4'd3, 8'h01);
        run_obs(cyc, nvalid);
        check("zero_burst_cycles", cyc, 32'd1);
        check("zero_burst_valid", nvalid, 32'd0);
        wait_drain("zero_burst_drain");

        // Nine pushes wrap the pointer; size 0 clamps to 1, so only buf[0] = 0x09 is sent.
        wr(4'd3, 8'h02);
        for (int i = 1; i <= 9; i++) begin
            wr(4'd4, 8'(i));
        end
        wr(4'd1, 8'd0);
        wr(4'd2, 8'd1);
        exp_byte(8'h09); exp_done();
        wr(4'd3, 8'h01);
        wait_drain("wrap_drain");

        // Writes during busy are ignored (buffer now 09,02..08).
        wr(4'd1, 8'd3);
        wr(4'd2, 8'd2);
        exp_byte(8'h09); exp_byte(8'h02); exp_byte(8'h03);
        exp_byte(8'h09); exp_byte(8'h02); exp_byte(8'h03);
        exp_done();
        wr(4'd3, 8'h01);
        wr(4'd1, 8'd5);
        wr(4'd3, 8'h01);
        tick();
        check("busy_flag", {31'd0, busy}, 32'd1);
        check("busy_tsize_locked", {24'd0, dataout1}, 32'd3);
        wait_drain("busy_drain");

        // Tsize above 8 clamps to 8 bytes per burst.
        wr(4'd1, 8'd12);
        wr(4'd2, 8'd1);
        tick();
        check("rb_tsize12", {24'd0, dataout1}, 32'd12);
        exp_byte(8'h09);
        for (int i = 2; i <= 8; i++) begin
            exp_byte(8'(i));
        end
        exp_done();
        wr(4'd3, 8'h01);
        wait_drain("clamp_drain");

        // Reset during the second burst aborts without a done pulse.
        wr(4'd1, 8'd3);
        wr(4'd2, 8'd2);
        exp_byte(8'h09); exp_byte(8'h02); exp_byte(8'h03);
        exp_byte(8'h09); exp_byte(8'h02); exp_byte(8'h03);
        exp_done();
        wr(4'd3, 8'h01);
        n = 0;
        while (exp_q.size() > 3 && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_burst2", {31'd0, n < 100}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_tx_data", {24'd0, tx_data}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_dataout1", {24'd0, dataout1}, 32'd0);
        check("abort_dataout2", {24'd0, dataout2}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            check("post_abort_done", {31'd0, done}, 32'd0);
            check("post_abort_busy", {31'd0, busy}, 32'd0);
            check("post_abort_valid", {31'd0, tx_valid}, 32'd0);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
